oled_spi_monitor: RTL and testbench

OLED_SPI_MONITOR -- requirements
Module: oled_spi_monitor

---
 rtl/oled_spi_monitor.sv | 195 +++++++++++++++++++
 tb/tb_oled_spi_monitor.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_monitor.sv
// Passive monitor for an SPI mode-0 OLED bus (SSD1306-style).
// Decodes bytes, tracks column/page windows and flags bus misuse.
module oled_spi_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NCOLS       = 128,
  parameter int unsigned NPAGES      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       oled_clk,
  input  logic       oled_mosi,
  input  logic       oled_dc,
  input  logic       oled_cs_n,
  input  logic       oled_rst_n,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic [6:0] pix_col,
  output logic [2:0] pix_page,
  output logic       frame_done,
  output logic       proto_err
);

  typedef enum logic [2:0] {
    CMD,
    COL_LO,
    COL_HI,
    PG_LO,
    PG_HI
  } state_t;

  localparam logic [6:0] COL_LAST = 7'(NCOLS - 1);
  localparam logic [2:0] PG_LAST  = 3'(NPAGES - 1);

  logic [SYNC_STAGES-1:0] clk_sy;
  logic [SYNC_STAGES-1:0] mosi_sy;
  logic [SYNC_STAGES-1:0] dc_sy;
  logic [SYNC_STAGES-1:0] cs_sy;
  logic [SYNC_STAGES-1:0] rst_sy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sy  <= '0;
      mosi_sy <= '0;
      dc_sy   <= '0;
      cs_sy   <= '1;
      rst_sy  <= '1;
    end else begin
      clk_sy  <= {clk_sy[SYNC_STAGES-2:0], oled_clk};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], oled_mosi};
      dc_sy   <= {dc_sy[SYNC_STAGES-2:0], oled_dc};
      cs_sy   <= {cs_sy[SYNC_STAGES-2:0], oled_cs_n};
      rst_sy  <= {rst_sy[SYNC_STAGES-2:0], oled_rst_n};
    end
  end

  logic clk_s, mosi_s, dc_s, cs_s, rst_s;
  assign clk_s  = clk_sy[SYNC_STAGES-1];
  assign mosi_s = mosi_sy[SYNC_STAGES-1];
  assign dc_s   = dc_sy[SYNC_STAGES-1];
  assign cs_s   = cs_sy[SYNC_STAGES-1];
  assign rst_s  = rst_sy[SYNC_STAGES-1];

  state_t     state;
  logic       clk_prev;
  logic       cs_prev;
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [6:0] arg_lo;
  logic [6:0] col_start, col_end, cur_col;
  logic [2:0] page_start, page_end, cur_page;

  logic       rise;
  logic       cs_rise;
  logic       done;
  logic [7:0] full;

  assign rise    = clk_s & ~clk_prev & ~cs_s;
  assign cs_rise = cs_s & ~cs_prev;
  assign done    = rise & (bit_cnt == 3'd7);
  assign full    = {sr, mosi_s};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= CMD;
      clk_prev     <= 1'b0;
      cs_prev      <= 1'b1;
      sr           <= '0;
      bit_cnt      <= '0;
      arg_lo       <= '0;
      col_start    <= '0;
      col_end      <= COL_LAST;
      cur_col      <= '0;
      page_start   <= '0;
      page_end     <= PG_LAST;
      cur_page     <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_data <= 1'b0;
      pix_col      <= '0;
      pix_page     <= '0;
      frame_done   <= 1'b0;
      proto_err    <= 1'b0;
    end else if (!rst_s) begin
      // edge trackers follow the bus so release cannot fake an edge
      state        <= CMD;
      clk_prev     <= clk_s;
      cs_prev      <= cs_s;
      sr           <= '0;
      bit_cnt      <= '0;
      arg_lo       <= '0;
      col_start    <= '0;
      col_end      <= COL_LAST;
      cur_col      <= '0;
      page_start   <= '0;
      page_end     <= PG_LAST;
      cur_page     <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_data <= 1'b0;
      pix_col      <= '0;
      pix_page     <= '0;
      frame_done   <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      clk_prev   <= clk_s;
      cs_prev    <= cs_s;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;

      if (rise) begin
        sr      <= full[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (cs_rise && bit_cnt != 3'd0) begin
        bit_cnt   <= '0;
        proto_err <= 1'b1;
      end

      if (done) begin
        byte_valid   <= 1'b1;
        byte_data    <= full;
        byte_is_data <= dc_s;
        if (dc_s) begin
          if (state != CMD) proto_err <= 1'b1;
          state    <= CMD;
          pix_col  <= cur_col;
          pix_page <= cur_page;
          if (cur_col == col_end) begin
            cur_col <= col_start;
            if (cur_page == page_end) begin
              cur_page   <= page_start;
              frame_done <= 1'b1;
            end else begin
              cur_page <= cur_page + 3'd1;
            end
          end else begin
            cur_col <= cur_col + 7'd1;
          end
        end else begin
          unique case (state)
            CMD: begin
              if (full == 8'h21) state <= COL_LO;
              else if (full == 8'h22) state <= PG_LO;
            end
            COL_LO: begin
              arg_lo <= full[6:0];
              state  <= COL_HI;
            end
            COL_HI: begin
              col_start <= arg_lo;
              col_end   <= full[6:0];
              cur_col   <= arg_lo;
              state     <= CMD;
            end
            PG_LO: begin
              arg_lo <= full[6:0];
              state  <= PG_HI;
            end
            PG_HI: begin
              page_start <= arg_lo[2:0];
              page_end   <= full[2:0];
              cur_page   <= arg_lo[2:0];
              state      <= CMD;
            end
            default: state <= CMD;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_monitor.sv
// Bench for oled_spi_monitor: directed and random bus traffic
// compared against a transaction-level model of the display window.
module tb_oled_spi_monitor;

  logic       clock;
  logic       reset;
  logic       oled_clk, oled_mosi, oled_dc, oled_cs_n, oled_rst_n;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;
  logic [6:0] pix_col;
  logic [2:0] pix_page;
  logic       frame_done;
  logic       proto_err;

  oled_spi_monitor #(
    .SYNC_STAGES(2),
    .NCOLS(128),
    .NPAGES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .oled_clk(oled_clk),
    .oled_mosi(oled_mosi),
    .oled_dc(oled_dc),
    .oled_cs_n(oled_cs_n),
    .oled_rst_n(oled_rst_n),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_is_data(byte_is_data),
    .pix_col(pix_col),
    .pix_page(pix_page),
    .frame_done(frame_done),
    .proto_err(proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       dc;
    logic [6:0] col;
    logic [2:0] pg;
    logic       fd;
    logic       pe;
    int         cyc;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  cyc = 0;
  int  rise_cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (byte_valid || frame_done || proto_err) begin
      obs_q.push_back('{byte_valid, byte_data, byte_is_data,
                        pix_col, pix_page, frame_done,
                        proto_err, cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Display model: cursor kept as a linear index inside the window
  int m_cs, m_ce, m_ps, m_pe, m_lin, m_args, m_arg0;
  bit m_iscol;

  task automatic model_reset();
    m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_lin = 0; m_args = 0; m_arg0 = 0; m_iscol = 0;
  endtask

  task automatic exp_push(input logic v, input logic [7:0] d,
                          input logic dc, input int col,
                          input int pg, input logic fd,
                          input logic pe);
    ev_t e;
    e.v = v; e.d = d; e.dc = dc;
    e.col = 7'(col); e.pg = 3'(pg);
    e.fd = fd; e.pe = pe; e.cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input logic dc);
    int w, h, col, pg, off;
    logic fd, pe;
    w = m_ce - m_cs + 1;
    h = m_pe - m_ps + 1;
    fd = 0; pe = 0; col = 0; pg = 0;
    if (dc) begin
      pe = (m_args != 0);
      m_args = 0;
      col = m_cs + m_lin % w;
      pg = m_ps + m_lin / w;
      m_lin++;
      if (m_lin == w * h) begin
        m_lin = 0;
        fd = 1;
      end
    end else if (m_args == 0) begin
      if (b == 8'h21) begin m_args = 2; m_iscol = 1; end
      else if (b == 8'h22) begin m_args = 2; m_iscol = 0; end
    end else if (m_args == 2) begin
      m_arg0 = int'(b);
      m_args = 1;
    end else begin
      m_args = 0;
      if (m_iscol) begin
        off = m_lin / w;
        m_cs = m_arg0 % 128;
        m_ce = int'(b) % 128;
        m_lin = off * (m_ce - m_cs + 1);
      end else begin
        off = m_lin % w;
        m_ps = m_arg0 % 8;
        m_pe = int'(b) % 8;
        m_lin = off;
      end
    end
    exp_push(1'b1, b, dc, col, pg, fd, pe);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    oled_mosi = b;
    oled_clk = 1'b0;
    clocks(4);
    oled_clk = 1'b1;
    rise_cyc = cyc;
    clocks(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    oled_dc = dc;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    model_byte(b, dc);
  endtask

  task automatic send_window(input int c0, input int c1,
                             input int p0, input int p1);
    send_byte(8'h21, 1'b0);
    send_byte(8'(c0), 1'b0);
    send_byte(8'(c1), 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'(p0), 1'b0);
    send_byte(8'(p1), 1'b0);
  endtask

  task automatic check_events(input string tag);
    int n;
    clocks(3);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_%0d_valid", tag, i), obs_q[i].v, exp_q[i].v);
      chk($sformatf("%s_%0d_err", tag, i), obs_q[i].pe, exp_q[i].pe);
      chk($sformatf("%s_%0d_frame", tag, i), obs_q[i].fd, exp_q[i].fd);
      if (exp_q[i].v) begin
        chk($sformatf("%s_%0d_data", tag, i), obs_q[i].d, exp_q[i].d);
        chk($sformatf("%s_%0d_dc", tag, i), obs_q[i].dc, exp_q[i].dc);
        if (exp_q[i].dc) begin
          chk($sformatf("%s_%0d_col", tag, i), obs_q[i].col,
              exp_q[i].col);
          chk($sformatf("%s_%0d_page", tag, i), obs_q[i].pg,
              exp_q[i].pg);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] outs();
    return 32'({byte_valid, byte_data, byte_is_data, pix_col,
                pix_page, frame_done, proto_err});
  endfunction

  initial begin
    int nfd;
    int c0, c1, p0, p1, nb;
    logic [7:0] r;

    reset = 1'b1;
    oled_clk = 1'b0;
    oled_mosi = 1'b0;
    oled_dc = 1'b0;
    oled_cs_n = 1'b1;
    oled_rst_n = 1'b1;
    model_reset();
    clocks(3);
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;
    clocks(4);
    chk("post_reset_outputs", outs(), 0);
    chk("post_reset_events", obs_q.size(), 0);
    oled_cs_n = 1'b0;
    clocks(6);

    // single command byte and its latency
    send_byte(8'hAF, 1'b0);
    clocks(3);
    chk("latency", (obs_q.size() > 0) ? obs_q[0].cyc - rise_cyc : -1, 3);
    check_events("cmd_af");

    // small 2x2 window
    send_window(2, 3, 6, 7);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), 1'b1);
    check_events("window2x2");

    // full-screen frame plus one
    send_window(0, 127, 0, 7);
    check_events("default_win");
    for (int i = 0; i < 1025; i++) send_byte(8'h00, 1'b1);
    clocks(3);
    chk("frame_count", obs_q.size(), 1025);
    nfd = 0;
    foreach (obs_q[i]) nfd += int'(obs_q[i].fd);
    chk("frame_done_total", nfd, 1);
    if (obs_q.size() == 1025) begin
      chk("frame_done_1024", obs_q[1023].fd, 1);
      chk("byte1025_addr", {obs_q[1024].col, obs_q[1024].pg}, 0);
    end
    check_events("frame");

    // chip select released mid-byte, then a silent release
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    clocks(2);
    oled_cs_n = 1'b1;
    exp_push(1'b0, 8'h00, 1'b0, 0, 0, 1'b0, 1'b1);
    clocks(6);
    oled_cs_n = 1'b0;
    clocks(4);
    send_byte(8'h5A, 1'b0);
    oled_cs_n = 1'b1;
    clocks(6);
    oled_cs_n = 1'b0;
    clocks(4);
    check_events("cs_abort");

    // data byte interrupting an argument sequence
    send_window(0, 127, 0, 7);
    send_byte(8'h21, 1'b0);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h33, 1'b1);
    check_events("arg_abort");

    // soft reset mid-frame and mid-byte
    send_window(40, 127, 3, 7);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    oled_rst_n = 1'b0;
    clocks(3);
    chk("soft_reset_outputs", outs(), 0);
    clocks(7);
    oled_rst_n = 1'b1;
    model_reset();
    clocks(4);
    send_byte(8'h77, 1'b1);
    send_byte(8'h21, 1'b0);
    send_byte(8'd5, 1'b0);
    send_byte(8'd5, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1);
    check_events("soft_reset");

    // random windows, data and stray commands
    for (int it = 0; it < 4; it++) begin
      c0 = $urandom_range(0, 120);
      c1 = c0 + $urandom_range(0, 7);
      p0 = $urandom_range(0, 7);
      p1 = $urandom_range(p0, 7);
      send_window(c0, c1, p0, p1);
      nb = $urandom_range(1, 10);
      for (int j = 0; j < nb; j++) begin
        case ($urandom_range(0, 5))
          0: begin
            r = 8'($urandom_range(0, 255));
            if (r == 8'h21 || r == 8'h22) r = 8'hAE;
            send_byte(r, 1'b0);
          end
          1: begin
            send_byte(8'h22, 1'b0);
            send_byte(8'($urandom_range(0, 7)), 1'b0);
          end
          default: ;
        endcase
        send_byte(8'($urandom_range(0, 255)), 1'b1);
      end
      check_events($sformatf("rand%0d", it));
    end

    // hard reset in the middle of a byte
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    oled_clk = 1'b0;
    clocks(3);
    chk("mid_byte_reset_outputs", outs(), 0);
    reset = 1'b0;
    model_reset();
    clocks(6);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h9C, 1'b1);
    check_events("hard_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
